// File: rtl/apu_audio_mixer.sv
// apu_audio_mixer
//   Mixes the NES APU channel levels into a single sample, box-car decimates
//   by 2^DECIM_LOG2, applies master volume, removes the DC offset with a leaky
//   tracker and clamps to an excess-128 byte for the sigma-delta DAC.
//   All stages advance only on the pipeline valid that follows SMP_VALID.
//
// Ports
//   CLK        system clock
//   RESET_N    asynchronous active-low reset
//   SMP_VALID  one-cycle strobe, channel levels valid this cycle
//   PULSE1/PULSE2/TRIANGLE/NOISE [3:0], DMC [6:0]  channel levels
//   VOLUME     [3:0] master volume (0 silent, 15 = 15/16)
//   MUTE       forces mid-scale output while dc tracking keeps running
//   DAC_OUT    [7:0] excess-128 sample
//   DAC_STB    one-cycle pulse whenever DAC_OUT updates
module apu_audio_mixer #(
    parameter int unsigned DECIM_LOG2 = 4,
    parameter int unsigned DC_SHIFT   = 8
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       SMP_VALID,
    input  logic [3:0] PULSE1,
    input  logic [3:0] PULSE2,
    input  logic [3:0] TRIANGLE,
    input  logic [3:0] NOISE,
    input  logic [6:0] DMC,
    input  logic [3:0] VOLUME,
    input  logic       MUTE,
    output logic [7:0] DAC_OUT,
    output logic       DAC_STB
);

    localparam int unsigned AW = 9 + DECIM_LOG2;
    // counter needs at least one bit even when no decimation is configured
    localparam int unsigned CW = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;

    // stage 1: weighted mix
    logic [8:0] pulse_sum;
    logic [8:0] mix_d;
    logic [8:0] mix_q;
    logic       mix_vld;

    always_comb begin
        pulse_sum = {5'd0, PULSE1} + {5'd0, PULSE2};
        mix_d     = (pulse_sum << 2)
                  + ({5'd0, TRIANGLE} << 1) + {5'd0, TRIANGLE}
                  + ({5'd0, NOISE} << 1)
                  + {2'd0, DMC};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mix_q   <= '0;
            mix_vld <= 1'b0;
        end else begin
            mix_vld <= SMP_VALID;
            if (SMP_VALID)
                mix_q <= mix_d;
        end
    end

    // stage 2: box-car accumulate
    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_sum;
    logic [CW-1:0] cnt_q;
    logic          grp_done;
    logic [8:0]    avg_q;
    logic          avg_vld;

    always_comb begin
        acc_sum  = acc_q + AW'(mix_q);
        // with DECIM_LOG2 = 0 the terminal count is 0, so every sample completes a group
        grp_done = (cnt_q == CW'((1 << DECIM_LOG2) - 1));
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            avg_q   <= '0;
            avg_vld <= 1'b0;
        end else begin
            avg_vld <= mix_vld && grp_done;
            if (mix_vld) begin
                if (grp_done) begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    avg_q <= acc_sum[DECIM_LOG2 +: 9];
                end else begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    // stage 3: master volume, floor of avg*VOLUME/16
    logic [8:0] scaled_q;
    logic       scl_vld;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            scaled_q <= '0;
            scl_vld  <= 1'b0;
        end else begin
            scl_vld <= avg_vld;
            if (avg_vld)
                scaled_q <= 9'((13'(avg_q) * 13'(VOLUME)) >> 4);
        end
    end

    // stage 4: dc removal (dc is 9.7 fixed point) and clamp
    logic        [15:0] dc_q;
    logic signed [16:0] dc_err;
    logic signed [16:0] dc_step;
    logic        [15:0] dc_next;
    logic signed [10:0] y;
    logic        [7:0]  dac_d;

    always_comb begin
        dc_err  = $signed({1'b0, scaled_q, 7'b0}) - $signed({1'b0, dc_q});
        dc_step = dc_err >>> DC_SHIFT;
        dc_next = 16'($signed({1'b0, dc_q}) + dc_step);
        // output uses the dc value from before this update
        y       = $signed({2'b0, scaled_q}) - $signed({2'b0, dc_q[15:7]}) + 11'sd128;
        if (MUTE)
            dac_d = 8'd128;
        else if (y < 11'sd0)
            dac_d = '0;
        else if (y > 11'sd255)
            dac_d = '1;
        else
            dac_d = y[7:0];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dc_q    <= '0;
            DAC_OUT <= 8'd128;
            DAC_STB <= 1'b0;
        end else begin
            DAC_STB <= scl_vld;
            if (scl_vld) begin
                dc_q    <= dc_next;
                DAC_OUT <= dac_d;
            end
        end
    end

endmodule

// File: tb/tb_apu_audio_mixer.sv
// tb_apu_audio_mixer
//   Directed bench for apu_audio_mixer. Three instances share the stimulus:
//   dut_a uses the default parameters, dut_b decimates by 4 (DECIM_LOG2=2),
//   dut_c has no decimation and a slow dc tracker (DC_SHIFT=12).
module tb_apu_audio_mixer;

    logic       CLK;
    logic       RESET_N;
    logic       SMP_VALID;
    logic [3:0] PULSE1, PULSE2, TRIANGLE, NOISE, VOLUME;
    logic [6:0] DMC;
    logic       MUTE;
    logic [7:0] dac_out_a, dac_out_b, dac_out_c;
    logic       dac_stb_a, dac_stb_b, dac_stb_c;

    int checks = 0;
    int errors = 0;

    int stb_a = 0, stb_b = 0, stb_c = 0;
    int last_a = 128, last_b = 128, last_c = 128;

    apu_audio_mixer dut_a (
        .CLK(CLK), .RESET_N(RESET_N), .SMP_VALID(SMP_VALID),
        .PULSE1(PULSE1), .PULSE2(PULSE2), .TRIANGLE(TRIANGLE), .NOISE(NOISE),
        .DMC(DMC), .VOLUME(VOLUME), .MUTE(MUTE),
        .DAC_OUT(dac_out_a), .DAC_STB(dac_stb_a)
    );

    apu_audio_mixer #(.DECIM_LOG2(2), .DC_SHIFT(8)) dut_b (
        .CLK(CLK), .RESET_N(RESET_N), .SMP_VALID(SMP_VALID),
        .PULSE1(PULSE1), .PULSE2(PULSE2), .TRIANGLE(TRIANGLE), .NOISE(NOISE),
        .DMC(DMC), .VOLUME(VOLUME), .MUTE(MUTE),
        .DAC_OUT(dac_out_b), .DAC_STB(dac_stb_b)
    );

    apu_audio_mixer #(.DECIM_LOG2(0), .DC_SHIFT(12)) dut_c (
        .CLK(CLK), .RESET_N(RESET_N), .SMP_VALID(SMP_VALID),
        .PULSE1(PULSE1), .PULSE2(PULSE2), .TRIANGLE(TRIANGLE), .NOISE(NOISE),
        .DMC(DMC), .VOLUME(VOLUME), .MUTE(MUTE),
        .DAC_OUT(dac_out_c), .DAC_STB(dac_stb_c)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // record every output strobe on the falling edge
    always @(negedge CLK) begin
        if (dac_stb_a) begin stb_a++; last_a = dac_out_a; end
        if (dac_stb_b) begin stb_b++; last_b = dac_out_b; end
        if (dac_stb_c) begin stb_c++; last_c = dac_out_c; end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int p1, input int p2, input int t, input int n, input int d);
        PULSE1   = 4'(p1);
        PULSE2   = 4'(p2);
        TRIANGLE = 4'(t);
        NOISE    = 4'(n);
        DMC      = 7'(d);
    endtask

    // one strobe, then enough cycles for its result to leave the pipeline
    task automatic smp();
        @(posedge CLK); #1 SMP_VALID = 1'b1;
        @(posedge CLK); #1 SMP_VALID = 1'b0;
        repeat (3) @(posedge CLK);
    endtask

    task automatic settle();
        @(negedge CLK); #1;
    endtask

    task automatic do_reset();
        #2 RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #3 RESET_N = 1'b1;
    endtask

    // reference: volume, dc tracker and clamp on integer arithmetic
    task automatic model_step(input int avg, input int vol, input int shift,
                              input bit mute, inout int dc, output int y);
        int scaled;
        int err;
        scaled = (avg * vol) / 16;
        y = scaled - (dc / 128) + 128;
        if (y < 0)   y = 0;
        if (y > 255) y = 255;
        if (mute)    y = 128;
        err = scaled * 128 - dc;
        dc  = dc + (err >>> shift);
    endtask

    int base, dc, exp_y, bad, mono, prev;

    initial begin
        RESET_N = 1'b0; SMP_VALID = 1'b0; MUTE = 1'b0; VOLUME = 4'd15;
        set_ch(0, 0, 0, 0, 0);
        #23 RESET_N = 1'b1;
        settle();
        check("rst_out_a", dac_out_a, 128);
        check("rst_stb_a", dac_stb_a, 0);
        check("rst_out_c", dac_out_c, 128);

        // silence: two groups of 16, mid-scale, dc untouched
        base = stb_a;
        repeat (32) smp();
        settle();
        check("zero_stb_count", stb_a - base, 2);
        check("zero_out", last_a, 128);
        check("zero_dc", int'(dut_a.dc_q), 0);

        // latency and decimation on dut_b: mixes 10,20,30,40, avg 25, scaled 23
        do_reset();
        base = stb_b;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_ch(1, 1, 0, 1, 0);
                1: set_ch(0, 0, 4, 4, 0);
                2: set_ch(3, 2, 2, 2, 0);
                default: set_ch(0, 0, 0, 0, 40);
            endcase
            @(posedge CLK); #1 SMP_VALID = 1'b1;
            @(posedge CLK); #1 SMP_VALID = 1'b0;
            if (i < 3) begin
                repeat (22) @(posedge CLK);
                #1 check("lat_no_early_stb", stb_b - base, 0);
            end else begin
                for (int k = 2; k <= 5; k++) begin
                    @(posedge CLK); #1;
                    check($sformatf("lat_stb_cyc%0d", k), dac_stb_b, (k == 4) ? 1 : 0);
                    if (k == 4) check("lat_out", dac_out_b, 151);
                end
            end
        end
        settle();
        check("lat_stb_count", stb_b - base, 1);

        // step response on dut_b: mix 120 -> avg 120, scaled 112
        do_reset();
        set_ch(15, 15, 0, 0, 0);
        dc = 0; bad = 0; mono = 0; prev = 255;
        for (int n = 0; n < 1200; n++) begin
            repeat (4) smp();
            settle();
            model_step(120, 15, 8, 1'b0, dc, exp_y);
            if (n == 0) check("step_first", last_b, 240);
            if (last_b != exp_y) bad++;
            if (last_b > prev) mono++;
            prev = last_b;
        end
        check("step_track_mismatches", bad, 0);
        check("step_monotonic_violations", mono, 0);
        check("step_final", last_b, exp_y);

        // mute one group mid-signal on dut_b
        do_reset();
        set_ch(15, 15, 0, 0, 0);
        dc = 0;
        for (int n = 0; n < 40; n++) begin
            repeat (4) smp();
            model_step(120, 15, 8, 1'b0, dc, exp_y);
        end
        settle();
        check("mute_pre", last_b, exp_y);
        MUTE = 1'b1;
        base = stb_b;
        repeat (4) smp();
        settle();
        model_step(120, 15, 8, 1'b1, dc, exp_y);
        check("mute_stb", stb_b - base, 1);
        check("mute_out", last_b, 128);
        MUTE = 1'b0;
        repeat (4) smp();
        settle();
        model_step(120, 15, 8, 1'b0, dc, exp_y);
        check("mute_resume", last_b, exp_y);

        // full-scale clamp on dut_c: mix 322 -> scaled 301, y 429
        do_reset();
        set_ch(15, 15, 15, 15, 127);
        dc = 0; bad = 0;
        smp();
        settle();
        model_step(322, 15, 12, 1'b0, dc, exp_y);
        check("clamp_high", last_c, 255);
        for (int n = 0; n < 2999; n++) begin
            smp();
            model_step(322, 15, 12, 1'b0, dc, exp_y);
        end
        settle();
        if (last_c != exp_y) bad++;
        set_ch(0, 0, 0, 0, 0);
        smp();
        settle();
        model_step(0, 15, 12, 1'b0, dc, exp_y);
        check("clamp_track_mismatches", bad, 0);
        check("clamp_low_model", last_c, exp_y);
        check("clamp_low", last_c, 0);

        // asynchronous reset mid-group on dut_a
        do_reset();
        set_ch(15, 15, 0, 0, 0);
        repeat (16) smp();
        settle();
        check("arst_pre_out", last_a, 240);
        set_ch(0, 0, 15, 15, 100);
        repeat (2) smp();
        @(negedge CLK); #2 RESET_N = 1'b0;
        #1;
        check("arst_out", dac_out_a, 128);
        check("arst_stb", dac_stb_a, 0);
        #14 RESET_N = 1'b1;
        set_ch(15, 15, 0, 0, 0);
        base = stb_a;
        repeat (15) smp();
        settle();
        check("arst_no_stb_15", stb_a - base, 0);
        smp();
        settle();
        check("arst_stb_16", stb_a - base, 1);
        check("arst_fresh_out", last_a, 240);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
